// File: rtl/simple_pkg.sv
// Shared types and constants for the execution sequencer: FSM state encoding,
// phase bit positions, and the width of the memory wait timer.
package simple_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_HALTED = 3'd3,
    ST_FAULT  = 3'd4
  } exec_state_t;

  localparam int PH_P0 = 0;
  localparam int PH_P1 = 1;
  localparam int PH_P2 = 2;
  localparam int PH_P3 = 3;

  // Wide enough for the largest tolerated timeout (255).
  localparam int WAIT_CNT_W = 8;

  function automatic logic is_active(exec_state_t s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/exec_wait_timer.sv
// Counts consecutive memory wait cycles while the core is executing and flags
// the cycle on which the wait has lasted longer than the tolerated limit.
module exec_wait_timer
  import simple_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic enable_i,
  input  logic mem_wait_i,
  output logic timeout_o
);

  logic [WAIT_CNT_W-1:0] wait_cnt_q;
  logic [WAIT_CNT_W-1:0] wait_cnt_d;
  logic                  counting;

  assign counting = enable_i & mem_wait_i;

  // Any cycle without a pending wait, or outside RUN/STEP, restarts the count.
  always_comb begin
    wait_cnt_d = '0;
    if (counting) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign timeout_o = counting & (wait_cnt_q == WAIT_CNT_W'(MEM_TIMEOUT));

endmodule

// File: rtl/exec_controller.sv
// Run/stop/single-step sequencer for the 4-phase core: drives the phase counter
// stall, counts retired instructions and traps memory wait timeouts.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | stopped at an instruction boundary, phase held
//   RUN     | executing continuously until stop or HALT
//   STEP    | executing one instruction, then back to IDLE
//   HALTED  | HALT retired; only reset leaves
//   FAULT   | memory wait exceeded the limit; only reset leaves
module exec_controller
  import simple_pkg::*;
#(
  parameter int COUNT_W     = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               step,
  input  logic [4:0]         phase,
  input  logic               halt_req,
  input  logic               mem_req,
  input  logic               mem_ready,
  output logic               stall,
  output logic               running,
  output logic               halted,
  output logic               fault,
  output logic [COUNT_W-1:0] instr_count
);

  exec_state_t        state_q, state_d;
  logic               stop_pend_q, stop_pend_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic active;
  logic mem_wait;
  logic at_p3;
  logic boundary;
  logic timeout;

  assign active   = is_active(state_q);
  assign mem_wait = mem_req & ~mem_ready;
  // Only a clean one-hot P3 marks the last phase; stray bits give no boundary.
  assign at_p3    = (phase == 5'(1 << PH_P3));
  assign stall    = ~active | mem_wait;
  assign boundary = active & ~mem_wait & at_p3;

  exec_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clock      (clock),
    .reset      (reset),
    .enable_i   (active),
    .mem_wait_i (mem_wait),
    .timeout_o  (timeout)
  );

  always_comb begin
    state_d     = state_q;
    stop_pend_d = stop_pend_q;
    count_d     = count_q;

    if (boundary) begin
      count_d = count_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
        end else if (step) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (timeout) begin
          state_d = ST_FAULT;
        end else if (boundary && halt_req) begin
          state_d = ST_HALTED;
        end else if (boundary && (stop_pend_q || stop)) begin
          state_d = ST_IDLE;
        end else if (stop) begin
          stop_pend_d = 1'b1;
        end
      end
      ST_STEP: begin
        if (timeout) begin
          state_d = ST_FAULT;
        end else if (boundary && halt_req) begin
          state_d = ST_HALTED;
        end else if (boundary) begin
          state_d = ST_IDLE;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      ST_FAULT:  state_d = ST_FAULT;
      default:   state_d = ST_IDLE;
    endcase

    // A pending stop belongs to the current run only.
    if (state_d != ST_RUN) begin
      stop_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      stop_pend_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      stop_pend_q <= stop_pend_d;
      count_q     <= count_d;
    end
  end

  assign running     = active;
  assign halted      = (state_q == ST_HALTED);
  assign fault       = (state_q == ST_FAULT);
  assign instr_count = count_q;

endmodule

// File: tb/tb_exec_controller.sv
// Directed bench for exec_controller with a behavioural phase counter that
// rotates the one-hot phase whenever stall is low.
module tb_exec_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        step = 1'b0;
  logic        halt_req = 1'b0;
  logic        mem_req = 1'b0;
  logic        mem_ready = 1'b0;
  logic [4:0]  phase;
  logic        stall, running, halted, fault;
  logic [15:0] instr_count;

  logic [4:0]  phase_q;
  logic        ovr_en = 1'b0;
  logic [4:0]  ovr_val = 5'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (reset) phase_q <= 5'b00001;
    else if (!stall) phase_q <= {1'b0, phase_q[2:0], phase_q[3]};
  end

  assign phase = ovr_en ? ovr_val : phase_q;

  exec_controller #(.COUNT_W(16), .MEM_TIMEOUT(15)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .step        (step),
    .phase       (phase),
    .halt_req    (halt_req),
    .mem_req     (mem_req),
    .mem_ready   (mem_ready),
    .stall       (stall),
    .running     (running),
    .halted      (halted),
    .fault       (fault),
    .instr_count (instr_count)
  );

  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    tick();
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall got %b want 1", stall); end
    n_tests++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running got %b want 0", running); end
    n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", halted); end
    n_tests++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got %b want 0", fault); end
    n_tests++; if (instr_count !== 16'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", instr_count); end
  endtask

  task automatic test_run;
    start = 1'b1; tick(); start = 1'b0;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL run_stall got %b want 0", stall); end
    n_tests++; if (running !== 1'b1) begin n_fail++; $display("FAIL run_running got %b want 1", running); end
    for (int i = 0; i < 12; i++) tick();
    n_tests++; if (instr_count !== 16'd3) begin n_fail++; $display("FAIL run_count got %0d want 3", instr_count); end
  endtask

  task automatic test_stop_boundary;
    tick();
    stop = 1'b1; tick(); stop = 1'b0;
    tick();
    n_tests++; if (running !== 1'b1) begin n_fail++; $display("FAIL stop_early got running=%b want 1", running); end
    n_tests++; if (instr_count !== 16'd3) begin n_fail++; $display("FAIL stop_count_mid got %0d want 3", instr_count); end
    tick();
    n_tests++; if (running !== 1'b0) begin n_fail++; $display("FAIL stop_idle got running=%b want 0", running); end
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL stop_stall got %b want 1", stall); end
    tick(); tick();
    n_tests++; if (instr_count !== 16'd4) begin n_fail++; $display("FAIL stop_count got %0d want 4", instr_count); end
  endtask

  task automatic test_step;
    int adv = 0;
    step = 1'b1; tick(); step = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!running) break;
      if (!stall) adv++;
      tick();
    end
    n_tests++; if (adv != 4) begin n_fail++; $display("FAIL step_advances got %0d want 4", adv); end
    n_tests++; if (running !== 1'b0 || stall !== 1'b1) begin n_fail++; $display("FAIL step_idle got running=%b stall=%b want 0/1", running, stall); end
    n_tests++; if (instr_count !== 16'd5) begin n_fail++; $display("FAIL step_count got %0d want 5", instr_count); end
  endtask

  task automatic test_start_step_same;
    start = 1'b1; step = 1'b1; tick(); start = 1'b0; step = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    n_tests++; if (running !== 1'b1) begin n_fail++; $display("FAIL startstep_run got running=%b want 1", running); end
    n_tests++; if (instr_count !== 16'd7) begin n_fail++; $display("FAIL startstep_count got %0d want 7", instr_count); end
  endtask

  task automatic test_halt_outside_p3;
    halt_req = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    halt_req = 1'b0;
    n_tests++; if (halted !== 1'b0 || running !== 1'b1) begin n_fail++; $display("FAIL halt_early got halted=%b running=%b want 0/1", halted, running); end
    tick();
    n_tests++; if (instr_count !== 16'd8) begin n_fail++; $display("FAIL halt_early_count got %0d want 8", instr_count); end
  endtask

  task automatic test_nonhot_phase;
    ovr_en = 1'b1; ovr_val = 5'b00000;
    for (int i = 0; i < 5; i++) tick();
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL nonhot_stall got %b want 0", stall); end
    ovr_val = 5'b11000; halt_req = 1'b1;
    tick(); tick();
    halt_req = 1'b0;
    n_tests++; if (instr_count !== 16'd8 || halted !== 1'b0) begin n_fail++; $display("FAIL nonhot_noretire got count=%0d halted=%b want 8/0", instr_count, halted); end
    ovr_en = 1'b0;
    tick();
    n_tests++; if (instr_count !== 16'd9) begin n_fail++; $display("FAIL nonhot_resume got %0d want 9", instr_count); end
  endtask

  task automatic test_mem_wait;
    mem_req = 1'b1; mem_ready = 1'b0;
    #1;
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL wait_same_cycle got stall=%b want 1", stall); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (stall !== 1'b1 || fault !== 1'b0) begin n_fail++; $display("FAIL wait_cycle%0d got stall=%b fault=%b want 1/0", i, stall, fault); end
    end
    mem_ready = 1'b1;
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL wait_ready got stall=%b want 0", stall); end
    tick();
    mem_req = 1'b0;
    n_tests++; if (running !== 1'b1 || fault !== 1'b0) begin n_fail++; $display("FAIL wait_after got running=%b fault=%b want 1/0", running, fault); end
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL ready_no_req got stall=%b want 0", stall); end
    mem_ready = 1'b0;
  endtask

  task automatic test_halt;
    tick(); tick();
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    n_tests++; if (halted !== 1'b1 || stall !== 1'b1 || running !== 1'b0) begin n_fail++; $display("FAIL halt_state got halted=%b stall=%b running=%b want 1/1/0", halted, stall, running); end
    n_tests++; if (instr_count !== 16'd10) begin n_fail++; $display("FAIL halt_count got %0d want 10", instr_count); end
    start = 1'b1; tick(); start = 1'b0;
    step = 1'b1; tick(); step = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    n_tests++; if (halted !== 1'b1 || running !== 1'b0 || instr_count !== 16'd10) begin n_fail++; $display("FAIL halt_sticky got halted=%b running=%b count=%0d want 1/0/10", halted, running, instr_count); end
  endtask

  task automatic test_timeout;
    do_reset();
    n_tests++; if (instr_count !== 16'd0 || halted !== 1'b0) begin n_fail++; $display("FAIL halt_reset got count=%0d halted=%b want 0/0", instr_count, halted); end
    start = 1'b1; tick(); start = 1'b0;
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    n_tests++; if (fault !== 1'b0 || running !== 1'b1) begin n_fail++; $display("FAIL timeout_early got fault=%b running=%b want 0/1", fault, running); end
    tick();
    n_tests++; if (fault !== 1'b1 || running !== 1'b0 || stall !== 1'b1) begin n_fail++; $display("FAIL timeout_fault got fault=%b running=%b stall=%b want 1/0/1", fault, running, stall); end
    mem_req = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    n_tests++; if (fault !== 1'b1 || stall !== 1'b1) begin n_fail++; $display("FAIL fault_sticky got fault=%b stall=%b want 1/1", fault, stall); end
    do_reset();
    n_tests++; if (fault !== 1'b0 || running !== 1'b0 || stall !== 1'b1 || instr_count !== 16'd0) begin n_fail++; $display("FAIL fault_reset got fault=%b running=%b stall=%b count=%0d want 0/0/1/0", fault, running, stall, instr_count); end
  endtask

  task automatic test_reset_mid;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    do_reset();
    n_tests++; if (running !== 1'b0 || instr_count !== 16'd0) begin n_fail++; $display("FAIL midreset got running=%b count=%0d want 0/0", running, instr_count); end
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    n_tests++; if (instr_count !== 16'd1 || running !== 1'b1) begin n_fail++; $display("FAIL midreset_restart got count=%0d running=%b want 1/1", instr_count, running); end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_run();
    test_stop_boundary();
    test_step();
    test_start_step_same();
    test_halt_outside_p3();
    test_nonhot_phase();
    test_mem_wait();
    test_halt();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
